// File: rtl/cfg_info_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfg_info_pkg
// Brief    : Word map layout and packing function for the config info block.
// Revision : 1.0
// ============================================================================
package cfg_info_pkg;

  localparam logic [31:0] CFG_INFO_MAGIC     = 32'hC7A6_C0F0;
  localparam int unsigned CFG_INFO_NUM_WORDS = 11;
  localparam int unsigned CFG_INFO_IDX_W     = $clog2(CFG_INFO_NUM_WORDS);

  localparam int unsigned CFG_W_MAGIC  = 0;
  localparam int unsigned CFG_W_WIDTHS = 1;
  localparam int unsigned CFG_W_ISA    = 2;
  localparam int unsigned CFG_W_PORTS  = 3;
  localparam int unsigned CFG_W_CACHE  = 4;
  localparam int unsigned CFG_W_TLB    = 5;
  localparam int unsigned CFG_W_BPRED  = 6;
  localparam int unsigned CFG_W_DMBASE = 7;
  localparam int unsigned CFG_W_HALT   = 8;
  localparam int unsigned CFG_W_EXCEPT = 9;
  localparam int unsigned CFG_W_CSUM   = 10;

  typedef logic [31:0] cfg_info_word_t;
  typedef cfg_info_word_t [CFG_INFO_NUM_WORDS-1:0] cfg_info_words_t;
  typedef logic [CFG_INFO_IDX_W-1:0] cfg_info_idx_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } cfg_dump_state_e;

  function automatic logic [7:0] sat8(input int unsigned v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [3:0] sat4(input int unsigned v);
    return (v > 32'd15) ? 4'hF : v[3:0];
  endfunction

  function automatic cfg_info_words_t pack_cfg_words(input config_pkg::cva6_cfg_t cfg);
    cfg_info_words_t w;
    cfg_info_word_t  csum;
    w = '0;
    w[CFG_W_MAGIC]  = CFG_INFO_MAGIC;
    w[CFG_W_WIDTHS] = {sat8(cfg.GPLEN), sat8(cfg.PLEN), sat8(cfg.VLEN), sat8(cfg.XLEN)};
    w[CFG_W_ISA]    = {7'b0, cfg.PerfCounterEn, cfg.SuperscalarEn, cfg.DebugEn, cfg.MmuPresent,
                       cfg.CvxifEn, cfg.XFVec, cfg.XF8, cfg.XF16ALT, cfg.XF16, cfg.RVZihpm,
                       cfg.RVZicntr, cfg.RVZiCond, cfg.RVZCMT, cfg.RVZCMP, cfg.RVZCB, cfg.ZKN,
                       cfg.RVV, cfg.RVU, cfg.RVS, cfg.RVH, cfg.RVF, cfg.RVD, cfg.RVC, cfg.RVB,
                       cfg.RVA};
    w[CFG_W_PORTS]  = {sat8(cfg.NUM_THREADS), sat4(cfg.NrRgprPorts), sat4(cfg.NrWbPorts),
                       sat8(cfg.NR_SB_ENTRIES), sat4(cfg.NrIssuePorts), sat4(cfg.NrCommitPorts)};
    w[CFG_W_CACHE]  = {sat8(cfg.DCACHE_SET_ASSOC), sat8(cfg.DCACHE_INDEX_WIDTH),
                       sat8(cfg.ICACHE_SET_ASSOC), sat8(cfg.ICACHE_INDEX_WIDTH)};
    w[CFG_W_TLB]    = {sat8(cfg.SharedTlbDepth), sat8(cfg.NrPMPEntries),
                       sat8(cfg.DataTlbEntries), sat8(cfg.InstrTlbEntries)};
    w[CFG_W_BPRED]  = {sat8(cfg.BHTHist), sat8(cfg.BHTEntries),
                       sat8(cfg.BTBEntries), sat8(cfg.RASDepth)};
    w[CFG_W_DMBASE] = 32'(cfg.DmBaseAddress);
    w[CFG_W_HALT]   = 32'(cfg.HaltAddress);
    w[CFG_W_EXCEPT] = 32'(cfg.ExceptionAddress);
    csum = '0;
    for (int i = 0; i < int'(CFG_W_CSUM); i++) begin
      csum = csum ^ w[i];
    end
    w[CFG_W_CSUM] = csum;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Module   : config_pkg
// Brief    : Core configuration record consumed by cfg_info_responder.
// Revision : 1.0
// ============================================================================
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned VLEN;
    int unsigned PLEN;
    int unsigned GPLEN;
    bit          RVA;
    bit          RVB;
    bit          RVC;
    bit          RVD;
    bit          RVF;
    bit          RVH;
    bit          RVS;
    bit          RVU;
    bit          RVV;
    bit          ZKN;
    bit          RVZCB;
    bit          RVZCMP;
    bit          RVZCMT;
    bit          RVZiCond;
    bit          RVZicntr;
    bit          RVZihpm;
    bit          XF16;
    bit          XF16ALT;
    bit          XF8;
    bit          XFVec;
    bit          CvxifEn;
    bit          MmuPresent;
    bit          DebugEn;
    bit          SuperscalarEn;
    bit          PerfCounterEn;
    int unsigned NrCommitPorts;
    int unsigned NrIssuePorts;
    int unsigned NR_SB_ENTRIES;
    int unsigned NrWbPorts;
    int unsigned NrRgprPorts;
    int unsigned NUM_THREADS;
    int unsigned ICACHE_INDEX_WIDTH;
    int unsigned ICACHE_SET_ASSOC;
    int unsigned DCACHE_INDEX_WIDTH;
    int unsigned DCACHE_SET_ASSOC;
    int unsigned InstrTlbEntries;
    int unsigned DataTlbEntries;
    int unsigned NrPMPEntries;
    int unsigned SharedTlbDepth;
    int unsigned RASDepth;
    int unsigned BTBEntries;
    int unsigned BHTEntries;
    int unsigned BHTHist;
    bit [63:0]   DmBaseAddress;
    bit [63:0]   HaltAddress;
    bit [63:0]   ExceptionAddress;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage
`default_nettype wire

// File: rtl/cfg_info_streamer.sv
`default_nettype none
// ============================================================================
// Module   : cfg_info_streamer
// Brief    : Walks the config word map out over a valid/ready stream.
// Revision : 1.0
// ============================================================================
module cfg_info_streamer
  import cfg_info_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  cfg_info_words_t i_words,
  input  logic            i_start,
  input  logic            i_ready,
  output logic            o_valid,
  output cfg_info_word_t  o_data,
  output logic            o_last,
  output logic            o_busy
);

  localparam cfg_info_idx_t c_LAST_IDX = cfg_info_idx_t'(CFG_INFO_NUM_WORDS - 1);

  cfg_dump_state_e r_state;
  cfg_info_idx_t   r_idx;
  logic            r_valid;
  cfg_info_word_t  r_data;
  logic            r_last;
  cfg_info_idx_t   w_idx_nxt;
  cfg_info_word_t  w_word_nxt;

  assign w_idx_nxt = r_idx + 1'b1;

  always_comb begin
    w_word_nxt = '0;
    for (int i = 0; i < int'(CFG_INFO_NUM_WORDS); i++) begin
      if (w_idx_nxt == cfg_info_idx_t'(i)) w_word_nxt = i_words[i];
    end
  end

  // Data is preloaded one word ahead so dump_data is a plain register output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_STREAM;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_data  <= i_words[0];
            r_last  <= (c_LAST_IDX == '0);
          end
        end
        ST_STREAM: begin
          if (r_valid && i_ready) begin
            if (r_last) begin
              r_state <= ST_IDLE;
              r_idx   <= '0;
              r_valid <= 1'b0;
              r_data  <= '0;
              r_last  <= 1'b0;
            end else begin
              r_idx  <= w_idx_nxt;
              r_data <= w_word_nxt;
              r_last <= (w_idx_nxt == c_LAST_IDX);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_busy  = (r_state == ST_STREAM);

endmodule
`default_nettype wire

// File: rtl/cfg_info_responder.sv
`default_nettype none
// ============================================================================
// Module   : cfg_info_responder
// Brief    : Serves the elaborated core configuration over a read port and a dump stream.
// Revision : 1.0
// ============================================================================
module cfg_info_responder
  import cfg_info_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [5:0]  addr_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        dump_start_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [31:0] dump_data_o,
  output logic        dump_last_o,
  output logic        dump_busy_o
);

  localparam int unsigned NUM_WORDS = CFG_INFO_NUM_WORDS;

  cfg_info_words_t w_words;
  cfg_info_word_t  w_rd_word;
  logic            w_gnt;
  logic            w_in_range;
  logic            w_busy;
  logic            r_rvalid;
  cfg_info_word_t  r_rdata;
  logic            r_err;

  assign w_words    = pack_cfg_words(CVA6Cfg);
  assign w_gnt      = req_i & ~w_busy;
  assign w_in_range = (addr_i < 6'(NUM_WORDS));

  // Out-of-range indices fall through to zero, which is also the error-response data.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      if (addr_i == 6'(i)) w_rd_word = w_words[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      r_rdata  <= w_gnt ? w_rd_word : '0;
      r_err    <= w_gnt & ~w_in_range;
    end
  end

  assign gnt_o    = w_gnt;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

  cfg_info_streamer u_streamer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_words (w_words),
    .i_start (dump_start_i),
    .i_ready (dump_ready_i),
    .o_valid (dump_valid_o),
    .o_data  (dump_data_o),
    .o_last  (dump_last_o),
    .o_busy  (w_busy)
  );

  assign dump_busy_o = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_cfg_info_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_info_responder
// Brief    : Directed self-checking bench for cfg_info_responder.
// Revision : 1.0
// ============================================================================
module tb_cfg_info_responder;

  function automatic config_pkg::cva6_cfg_t mk_cfg();
    config_pkg::cva6_cfg_t c;
    c = config_pkg::cva6_cfg_empty;
    c.XLEN = 64; c.VLEN = 128; c.PLEN = 56; c.GPLEN = 41;
    c.RVA = 1'b1; c.RVC = 1'b1; c.RVD = 1'b1; c.RVF = 1'b1; c.RVS = 1'b1; c.RVU = 1'b1;
    c.RVZCB = 1'b1; c.RVZiCond = 1'b1; c.RVZicntr = 1'b1; c.RVZihpm = 1'b1;
    c.CvxifEn = 1'b1; c.MmuPresent = 1'b1; c.DebugEn = 1'b1; c.PerfCounterEn = 1'b1;
    c.NrCommitPorts = 2; c.NrIssuePorts = 20; c.NR_SB_ENTRIES = 8;
    c.NrWbPorts = 4; c.NrRgprPorts = 2; c.NUM_THREADS = 1;
    c.ICACHE_INDEX_WIDTH = 12; c.ICACHE_SET_ASSOC = 4;
    c.DCACHE_INDEX_WIDTH = 12; c.DCACHE_SET_ASSOC = 8;
    c.InstrTlbEntries = 16; c.DataTlbEntries = 16; c.NrPMPEntries = 8; c.SharedTlbDepth = 64;
    c.RASDepth = 2; c.BTBEntries = 300; c.BHTEntries = 128; c.BHTHist = 3;
    c.DmBaseAddress = 64'h0000_0001_0000_0800;
    c.HaltAddress = 64'h0000_0000_0000_0840;
    c.ExceptionAddress = 64'h0000_0000_0000_0808;
    return c;
  endfunction

  localparam config_pkg::cva6_cfg_t TB_CFG = mk_cfg();

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [5:0]  addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        dump_start;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        dump_busy;

  int          n_checks = 0;
  int          n_errs = 0;
  logic [31:0] exp_w [11];

  always #5 clk = ~clk;

  cfg_info_responder #(.CVA6Cfg(TB_CFG)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .addr_i       (addr),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .err_o        (err),
    .dump_start_i (dump_start),
    .dump_valid_o (dump_valid),
    .dump_ready_i (dump_ready),
    .dump_data_o  (dump_data),
    .dump_last_o  (dump_last),
    .dump_busy_o  (dump_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] xacc;
    int          exp_idx;
    int          k;
    int          cyc;

    // Hand-computed map for TB_CFG (NrIssuePorts and BTBEntries saturate).
    exp_w[0]  = 32'hC7A6_C0F0;
    exp_w[1]  = 32'h2938_8040;
    exp_w[2]  = 32'h0170_E4DD;
    exp_w[3]  = 32'h0124_08F2;
    exp_w[4]  = 32'h080C_040C;
    exp_w[5]  = 32'h4008_1010;
    exp_w[6]  = 32'h0380_FF02;
    exp_w[7]  = 32'h0000_0800;
    exp_w[8]  = 32'h0000_0840;
    exp_w[9]  = 32'h0000_0808;
    exp_w[10] = 32'hA54E_4FC9;

    rst = 1'b1; req = 1'b0; addr = '0; dump_start = 1'b0; dump_ready = 1'b0;
    repeat (3) tick();
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dvalid", 32'(dump_valid), 32'd0);
    check("rst_ddata", dump_data, 32'd0);
    check("rst_dlast", 32'(dump_last), 32'd0);
    check("rst_busy", 32'(dump_busy), 32'd0);
    rst = 1'b0;

    // Back-to-back reads of the whole map.
    xacc = '0;
    req = 1'b1; addr = 6'd0;
    #1 check("gnt_idle", 32'(gnt), 32'd1);
    for (int i = 0; i < 11; i++) begin
      tick();
      check($sformatf("rd_valid_%0d", i), 32'(rvalid), 32'd1);
      check($sformatf("rd_data_%0d", i), rdata, exp_w[i]);
      check($sformatf("rd_err_%0d", i), 32'(err), 32'd0);
      if (i == 1) begin
        check("w1_plen", 32'(rdata[23:16]), 32'h38);
        check("w1_gplen", 32'(rdata[31:24]), 32'h29);
      end
      if (i < 10) begin
        xacc = xacc ^ rdata;
        addr = 6'(i + 1);
      end else begin
        check("csum_xor", rdata, xacc);
        req = 1'b0;
      end
    end
    tick();
    check("rd_idle_valid", 32'(rvalid), 32'd0);
    check("rd_idle_data", rdata, 32'd0);

    // Out-of-range indices.
    req = 1'b1; addr = 6'd11;
    tick();
    check("oor11_valid", 32'(rvalid), 32'd1);
    check("oor11_data", rdata, 32'd0);
    check("oor11_err", 32'(err), 32'd1);
    addr = 6'd63;
    tick();
    check("oor63_data", rdata, 32'd0);
    check("oor63_err", 32'(err), 32'd1);
    req = 1'b0;
    tick();
    check("oor_idle_err", 32'(err), 32'd0);

    // Dump with stalls, read request held throughout.
    dump_start = 1'b1; req = 1'b1; addr = 6'd2;
    #1 check("gnt_with_start", 32'(gnt), 32'd1);
    tick();
    dump_start = 1'b0;
    check("simul_rvalid", 32'(rvalid), 32'd1);
    check("simul_rdata", rdata, exp_w[2]);
    check("dump_busy_on", 32'(dump_busy), 32'd1);
    exp_idx = 0; k = 0; cyc = 0;
    while (exp_idx < 11 && cyc < 100) begin
      dump_ready = (k % 3 == 0);
      k++;
      #1;
      check("stall_gnt", 32'(gnt), 32'd0);
      check("dump_valid", 32'(dump_valid), 32'd1);
      check($sformatf("dump_data_%0d", exp_idx), dump_data, exp_w[exp_idx]);
      check("dump_last", 32'(dump_last), 32'(exp_idx == 10));
      if (cyc > 0) check("stream_rvalid", 32'(rvalid), 32'd0);
      if (dump_ready) exp_idx++;
      tick();
      cyc++;
    end
    check("dump_count", 32'(exp_idx), 32'd11);
    dump_ready = 1'b0;
    #1;
    check("post_busy", 32'(dump_busy), 32'd0);
    check("post_valid", 32'(dump_valid), 32'd0);
    check("post_last", 32'(dump_last), 32'd0);
    check("post_gnt", 32'(gnt), 32'd1);
    tick();
    check("post_rvalid", 32'(rvalid), 32'd1);
    check("post_rdata", rdata, exp_w[2]);
    req = 1'b0;
    tick();

    // Reset after the fourth handshake, then restart.
    dump_start = 1'b1; dump_ready = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int h = 0; h < 4; h++) begin
      check($sformatf("pre_rst_data_%0d", h), dump_data, exp_w[h]);
      tick();
    end
    check("pre_rst_data_4", dump_data, exp_w[4]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(dump_valid), 32'd0);
    check("mid_rst_busy", 32'(dump_busy), 32'd0);
    check("mid_rst_data", dump_data, 32'd0);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    check("restart_valid", 32'(dump_valid), 32'd1);
    check("restart_data", dump_data, exp_w[0]);

    // A granted read in the reset cycle is dropped.
    rst = 1'b1;
    tick();
    rst = 1'b0; dump_ready = 1'b0;
    req = 1'b1; addr = 6'd1;
    #1 check("drop_gnt", 32'(gnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 1'b0;
    check("drop_rvalid", 32'(rvalid), 32'd0);
    check("drop_rdata", rdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
